// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity sense and default bit timing.
// The PARITY state is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY  = 3'd3,
`endif
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int CLKS_PER_BIT_DEFAULT = 87;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts enabled cycles and pulses bit_end on the last cycle
// of each bit, restarting from zero at every bit boundary.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, optional parity, STOP_BITS).
// Define UART_TX_PARITY_EN to compile in the PARITY state and parity generation.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | line high, o_Ready=1, accepts i_DV
//   START   | start bit (0) for one bit period
//   DATA    | data bits from latched word, LSB first
//   PARITY  | parity bit (only with UART_TX_PARITY_EN)
//   STOP    | line high for STOP_BITS bit periods
//   CLEANUP | one cycle, o_Sig_Done pulse, i_DV ignored
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 i_Rst_L,
    input  logic                 i_DV,
    input  logic [DATA_BITS-1:0] i_Data,
    output logic                 o_Sig_Active,
    output logic                 o_Serial_Data,
    output logic                 o_Sig_Done,
    output logic                 o_Ready
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_tx_param: illegal parameter set");
    end

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] data_q;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 bit_end;
    logic                 cnt_en;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
    logic            par_q;
`endif

    assign cnt_en = (state != IDLE) && (state != CLEANUP);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .rst_n  (i_Rst_L),
        .clear  (!cnt_en),
        .enable (cnt_en),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= IDLE;
            data_q        <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            o_Serial_Data <= 1'b1;
            o_Sig_Active  <= 1'b0;
            o_Sig_Done    <= 1'b0;
            o_Ready       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_Sig_Done <= 1'b0;
                    if (i_DV) begin
                        data_q        <= i_Data;
`ifdef UART_TX_PARITY_EN
                        par_q         <= ^i_Data ^ PAR_SENSE;
`endif
                        bit_idx       <= '0;
                        stop_idx      <= 1'b0;
                        o_Serial_Data <= 1'b0;
                        o_Sig_Active  <= 1'b1;
                        o_Ready       <= 1'b0;
                        state         <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        o_Serial_Data <= data_q[0];
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            o_Serial_Data <= par_q;
                            state         <= PARITY;
`else
                            o_Serial_Data <= 1'b1;
                            state         <= STOP;
`endif
                        end else begin
                            // Shift the latched word so the next bit is always at [1].
                            bit_idx       <= bit_idx + 1'b1;
                            data_q        <= data_q >> 1;
                            o_Serial_Data <= data_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        o_Serial_Data <= 1'b1;
                        state         <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop_idx == LAST_STOP) begin
                            o_Sig_Active <= 1'b0;
                            o_Sig_Done   <= 1'b1;
                            state        <= CLEANUP;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                CLEANUP: begin
                    o_Sig_Done <= 1'b0;
                    o_Ready    <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    o_Serial_Data <= 1'b1;
                    o_Sig_Active  <= 1'b0;
                    o_Sig_Done    <= 1'b0;
                    o_Ready       <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: stimulus queues expected frames, a monitor
// checks the serial line cycle by cycle; a second instance covers 5-bit, 2-stop frames.
module tb_uart_tx_param;

    localparam int C  = 4;
    localparam int D0 = 8;
    localparam int S0 = 1;
    localparam int D1 = 5;
    localparam int S1 = 2;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L0 = (1 + D0 + P + S0) * C;
    localparam int L1 = (1 + D1 + P + S1) * C;

    typedef struct {
        logic [15:0] bits;
        int          acc;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv0   = 1'b0;
    logic [7:0] data0 = '0;
    logic       dv1   = 1'b0;
    logic [4:0] data1 = '0;
    logic       act0, ser0, done0, rdy0;
    logic       act1, ser1, done1, rdy1;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   n_expect_done = 0;
    int   n_abort = 0;
    int   next_free = 0;
    int   last_acc = 0;

    uart_tx_param #(
        .CLKS_PER_BIT(C), .DATA_BITS(D0), .STOP_BITS(S0), .PARITY_ODD(0)
    ) dut0 (
        .clk(clk), .i_Rst_L(rst_n), .i_DV(dv0), .i_Data(data0),
        .o_Sig_Active(act0), .o_Serial_Data(ser0), .o_Sig_Done(done0), .o_Ready(rdy0)
    );

    uart_tx_param #(
        .CLKS_PER_BIT(C), .DATA_BITS(D1), .STOP_BITS(S1), .PARITY_ODD(1)
    ) dut1 (
        .clk(clk), .i_Rst_L(rst_n), .i_DV(dv1), .i_Data(data1),
        .o_Sig_Active(act1), .o_Serial_Data(ser1), .o_Sig_Done(done1), .o_Ready(rdy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done0 === 1'b1) n_done++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame as a list of bit values: start, data LSB first, parity, then stop/filler high.
    function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nd, input bit odd);
        logic [15:0] b   = '1;
        logic        par = odd;
        b[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            b[1 + i] = d[i];
            par      = par ^ d[i];
        end
        if (P == 1) b[1 + nd] = par;
        return b;
    endfunction

    // mode: 0 quiet wait, 1 random i_DV noise plus a forced mid-DATA pulse, 2 i_DV held high
    task automatic send0(input logic [7:0] d, input int mode);
        exp_t e;
        int   prev = last_acc;
        while (cyc + 1 < next_free) begin
            if (mode == 2) begin
                dv0 = 1'b1;
            end else if (mode == 1) begin
                dv0   = ($urandom_range(0, 5) == 0) || (cyc + 1 == prev + 3 * C);
                data0 = 8'($urandom);
            end else begin
                dv0 = 1'b0;
            end
            @(negedge clk);
        end
        dv0    = 1'b1;
        data0  = d;
        e.bits = frame_bits({1'b0, d}, D0, 1'b0);
        e.acc  = cyc + 1;
        sb.push_back(e);
        last_acc  = e.acc;
        next_free = e.acc + L0 + 2;
        n_expect_done++;
        @(negedge clk);
        data0 = 8'($urandom);
        if (mode != 2) dv0 = 1'b0;
    endtask

    task automatic run_dut1(input logic [4:0] d);
        logic [15:0] b;
        b     = frame_bits({4'b0, d}, D1, 1'b1);
        dv1   = 1'b1;
        data1 = d;
        @(negedge clk);
        dv1   = 1'b0;
        data1 = 5'h0;
        for (int k = 0; k < L1; k++) begin
            check("d5_line", ser1, b[k / C]);
            check("d5_flags", {act1, rdy1, done1}, 3'b100);
            @(negedge clk);
        end
        check("d5_done", {act1, rdy1, done1, ser1}, 4'b0011);
        @(negedge clk);
        check("d5_idle", {act1, rdy1, done1, ser1}, 4'b0101);
    endtask

    initial begin : monitor
        exp_t e;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && act0 === 1'b1) begin
                check("frame_expected", sb.size() != 0, 1);
                if (sb.size() == 0) begin
                    for (int w = 0; w < L0 + 4 && act0 === 1'b1; w++) @(negedge clk);
                end else begin
                    e = sb.pop_front();
                    check("start_cycle", cyc, e.acc);
                    aborted = 1'b0;
                    for (int k = 0; k < L0; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        check("line", ser0, e.bits[k / C]);
                        check("flags", {act0, rdy0, done0}, 3'b100);
                    end
                    if (aborted) begin
                        n_abort++;
                    end else begin
                        @(negedge clk);
                        check("cleanup", {act0, rdy0, done0, ser0}, 4'b0011);
                        @(negedge clk);
                        check("idle_gap", {act0, rdy0, done0, ser0}, 4'b0101);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        dv0   = 1'b1;
        data0 = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_dut0", {act0, rdy0, done0, ser0}, 4'b0101);
        check("rst_dut1", {act1, rdy1, done1, ser1}, 4'b0101);

        // Release reset with i_DV already high: the first edge must accept.
        rst_n     = 1'b1;
        next_free = cyc + 1;
        send0(8'h64, 0);
        run_dut1(5'h1F);

        send0(8'h5A, 0);
        send0(8'hC3, 1);

        send0(8'hA5, 2);
        send0(8'h3C, 2);
        dv0 = 1'b0;

        for (int i = 0; i < 12; i++) send0(8'($urandom), (i % 3 == 2) ? 2 : 1);
        dv0 = 1'b0;

        // Abort a frame during DATA bit 3 (frame bit index 4).
        send0(8'h96, 0);
        while (cyc < last_acc + 4 * C + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_line", ser0, 1'b1);
        check("abort_flags", {act0, rdy0, done0}, 3'b010);
        n_expect_done--;
        repeat (2) @(negedge clk);
        check("abort_hold", {act0, rdy0, done0, ser0}, 4'b0101);
        rst_n     = 1'b1;
        next_free = cyc + 1;
        send0(8'h81, 0);

        while (cyc < next_free + 2) @(negedge clk);
        check("queue_empty", sb.size(), 0);
        check("done_pulses", n_done, n_expect_done);
        check("aborted_frames", n_abort, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
